// File: rtl/fibo_checker.sv
// Sink-side checker for a Fibonacci stream: compares each accepted term against
// an internally generated reference and reports pass, first bad index and overflow.
module fibo_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] terms,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_index,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] terms_q;
  logic [WIDTH-1:0] prev, cur;
  logic [WIDTH:0]   expected;
  logic             mismatch_seen;
  logic             accept, bad, last;

  // Indices 0 and 1 are seeded; from index 2 on the reference is prev+cur with carry.
  always_comb begin
    if (term_count == '0)
      expected = '0;
    else if (term_count == CNT_W'(1))
      expected = (WIDTH+1)'(1);
    else
      expected = {1'b0, prev} + {1'b0, cur};
  end

  assign accept = in_valid && (state == RUN);
  assign bad    = (in_data != expected[WIDTH-1:0]) || expected[WIDTH];
  assign last   = (term_count + CNT_W'(1)) == terms_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (terms == '0) ? REPORT : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (accept && last) state_nxt = REPORT;
      end
      REPORT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      terms_q       <= '0;
      prev          <= '0;
      cur           <= '0;
      term_count    <= '0;
      err_index     <= '1;
      pass          <= 1'b0;
      overflow      <= 1'b0;
      mismatch_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            terms_q       <= terms;
            prev          <= '0;
            cur           <= '0;
            term_count    <= '0;
            err_index     <= '1;
            overflow      <= 1'b0;
            mismatch_seen <= 1'b0;
            // An empty run goes straight to REPORT, so its result is set here.
            pass          <= (terms == '0);
          end
        end
        RUN: begin
          if (accept) begin
            prev       <= cur;
            cur        <= expected[WIDTH-1:0];
            term_count <= term_count + CNT_W'(1);
            if (expected[WIDTH]) overflow <= 1'b1;
            if (bad && !mismatch_seen) begin
              err_index     <= term_count;
              mismatch_seen <= 1'b1;
            end
            if (last) pass <= !(mismatch_seen || bad);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_checker.sv
// Randomized self-checking bench for fibo_checker against a true-Fibonacci model.
module tb_fibo_checker;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] terms;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_index;
  logic [CNT_W-1:0] term_count;
  logic             overflow;

  fibo_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .terms(terms),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .pass(pass), .err_index(err_index),
    .term_count(term_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  longint unsigned fib [0:63];
  logic [WIDTH-1:0] stim [0:63];

  // Observations from the most recent run
  int   r_done_seen, r_done_cyc, r_last_acc, r_acc, r_ready_drop;
  logic r_pass, r_ov, r_rdy_done, r_busy_done;
  logic [CNT_W-1:0] r_err, r_tc;

  // Model results
  logic m_pass, m_ov;
  logic [CNT_W-1:0] m_err;

  function automatic void model_eval(input int n);
    m_pass = 1'b1;
    m_ov   = 1'b0;
    m_err  = 8'hFF;
    for (int i = 0; i < n; i++) begin
      logic wrong;
      wrong = (fib[i] >= 64'h1_0000_0000) || (longint'(stim[i]) != (fib[i] & 64'hFFFF_FFFF));
      if (fib[i] >= 64'h1_0000_0000) m_ov = 1'b1;
      if (wrong && m_pass) m_err = CNT_W'(i);
      if (wrong) m_pass = 1'b0;
    end
  endfunction

  task automatic load_clean(input int n);
    for (int i = 0; i < 64; i++) stim[i] = (i < n) ? WIDTH'(fib[i] & 64'hFFFF_FFFF) : '0;
  endtask

  // Drives one run; mid_start_idx >= 0 pulses start again once that many terms are in.
  task automatic drive_run(input int n, input int gap_pct, input int mid_start_idx);
    int idx, cyc;
    logic v;
    @(negedge clk);
    start = 1'b1;
    terms = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    terms = CNT_W'($urandom_range(255));
    idx = 0; cyc = 0;
    r_done_seen = 0; r_last_acc = -1; r_ready_drop = 0; r_done_cyc = -1;
    while (!r_done_seen && cyc < 2000) begin
      if (done) begin
        r_done_seen = 1;
        r_done_cyc  = cyc;
        r_pass      = pass;
        r_err       = err_index;
        r_tc        = term_count;
        r_ov        = overflow;
        r_rdy_done  = in_ready;
        r_busy_done = busy;
      end else begin
        if (!in_ready) r_ready_drop = 1;
        v = (idx < n) && ($urandom_range(99) >= gap_pct);
        in_valid = v;
        in_data  = v ? stim[idx] : $urandom;
        start    = (mid_start_idx >= 0) && (idx == mid_start_idx);
        if (v && in_ready) begin
          idx++;
          r_last_acc = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    in_valid = 1'b0;
    r_acc = idx;
  endtask

  task automatic check_run(input string name, input int n);
    model_eval(n);
    total++;
    if (r_done_seen !== 1) begin
      bad++; $display("FAIL %s done_seen: got %0d want 1", name, r_done_seen);
    end
    total++;
    if (r_done_cyc !== r_last_acc + 1) begin
      bad++; $display("FAIL %s done_latency: done cyc %0d want %0d", name, r_done_cyc, r_last_acc + 1);
    end
    total++;
    if (r_pass !== m_pass) begin
      bad++; $display("FAIL %s pass: got %0b want %0b", name, r_pass, m_pass);
    end
    total++;
    if (r_err !== m_err) begin
      bad++; $display("FAIL %s err_index: got %0d want %0d", name, r_err, m_err);
    end
    total++;
    if (r_tc !== CNT_W'(n) || r_acc != n) begin
      bad++; $display("FAIL %s term_count: got %0d (acc %0d) want %0d", name, r_tc, r_acc, n);
    end
    total++;
    if (r_ov !== m_ov) begin
      bad++; $display("FAIL %s overflow: got %0b want %0b", name, r_ov, m_ov);
    end
    total++;
    if (r_rdy_done !== 1'b0 || r_busy_done !== 1'b0) begin
      bad++; $display("FAIL %s ready_busy_at_done: got %0b/%0b want 0/0", name, r_rdy_done, r_busy_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, busy, done, pass, overflow} !== 5'b0 || err_index !== 8'hFF || term_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: rdy=%0b busy=%0b done=%0b pass=%0b ov=%0b err=%0h tc=%0d want 0 0 0 0 0 ff 0",
               in_ready, busy, done, pass, overflow, err_index, term_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean;
    load_clean(10);
    drive_run(10, 0, -1);
    check_run("clean10", 10);
    total++;
    if (r_ready_drop !== 0) begin
      bad++; $display("FAIL clean10 ready_drop: got %0d want 0", r_ready_drop);
    end
  endtask

  task automatic test_single_error;
    load_clean(10);
    stim[5] = 32'd6;
    drive_run(10, 0, -1);
    check_run("err5", 10);
    total++;
    if (r_ready_drop !== 0) begin
      bad++; $display("FAIL err5 ready_drop: got %0d want 0", r_ready_drop);
    end
  endtask

  task automatic test_gaps_two_errors;
    load_clean(8);
    stim[3] = stim[3] + 32'd7;
    stim[6] = stim[6] ^ 32'h100;
    drive_run(8, 40, -1);
    check_run("gaps_err3_6", 8);
  endtask

  task automatic test_overflow;
    load_clean(49);
    drive_run(49, 0, -1);
    check_run("overflow49", 49);
    total++;
    if (stim[48] !== 32'd512559680) begin
      bad++; $display("FAIL overflow49 model_f48: got %0d want 512559680", stim[48]);
    end
  endtask

  task automatic test_zero_and_ignored_start;
    drive_run(0, 0, -1);
    check_run("zero_terms", 0);
    total++;
    if (r_done_cyc !== 0) begin
      bad++; $display("FAIL zero_terms done_cycle: got %0d want 0", r_done_cyc);
    end
    load_clean(4);
    drive_run(4, 0, 2);
    check_run("ignored_start", 4);
  endtask

  task automatic test_reset_mid_run;
    int idx, cyc, done_hits;
    load_clean(10);
    @(negedge clk);
    start = 1'b1; terms = 8'd10;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 100) begin
      in_valid = 1'b1;
      in_data  = stim[idx];
      if (in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    done_hits = 0;
    @(negedge clk);
    total++;
    if ({in_ready, busy, done, pass, overflow} !== 5'b0 || err_index !== 8'hFF || term_count !== 8'h00) begin
      bad++;
      $display("FAIL midrun_reset_values: rdy=%0b busy=%0b done=%0b pass=%0b ov=%0b err=%0h tc=%0d",
               in_ready, busy, done, pass, overflow, err_index, term_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_hits++;
      @(negedge clk);
    end
    total++;
    if (done_hits !== 0) begin
      bad++; $display("FAIL midrun_no_done: got %0d done pulses want 0", done_hits);
    end
    load_clean(3);
    drive_run(3, 0, -1);
    check_run("after_reset3", 3);
  endtask

  task automatic test_back_to_back;
    load_clean(5);
    drive_run(5, 0, -1);
    check_run("b2b_first", 5);
    drive_run(5, 0, -1);
    check_run("b2b_second", 5);
  endtask

  task automatic test_random;
    for (int k = 0; k < 5; k++) begin
      int n, e;
      n = $urandom_range(45, 1);
      load_clean(n);
      if ($urandom_range(1) == 1) begin
        e = $urandom_range(n - 1);
        stim[e] = stim[e] ^ (32'h1 << $urandom_range(31));
      end
      drive_run(n, $urandom_range(50), -1);
      check_run("random", n);
    end
  endtask

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];
    reset = 1'b0; start = 1'b0; terms = '0; in_valid = 1'b0; in_data = '0;
    test_reset;
    test_clean;
    test_single_error;
    test_gaps_two_errors;
    test_overflow;
    test_zero_and_ignored_start;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
